// File: rtl/div_rem_seq_ctrl.sv
// Iterative restoring radix-2 divider for RV32M div/divu/rem/remu.
// start/busy/done handshake lets the core stall while it runs.
module div_rem_seq_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_W      = $clog2(DATA_WIDTH) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [4:0]            alu_ctrl,
  input  logic [DATA_WIDTH-1:0] src1_value,
  input  logic [DATA_WIDTH-1:0] src2_value,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result
);

  localparam int W = DATA_WIDTH;
  localparam logic [W-1:0] MIN = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, DIV, FIX, DONE} state_t;

  state_t         state;
  logic [W-1:0]   rem_reg;
  logic [W-1:0]   quo_reg;
  logic [W-1:0]   divisor;
  logic [CNT_W-1:0] cnt;
  logic           sign_a;
  logic           sign_b;
  logic           is_rem;

  logic           valid_op;
  logic           sgn_op;
  logic           rem_op;

  always_comb begin
    valid_op = 1'b1;
    sgn_op   = 1'b0;
    rem_op   = 1'b0;
    unique case (1'b1)
      (alu_ctrl == 5'b10110): sgn_op = 1'b1;
      (alu_ctrl == 5'b10111): ;
      (alu_ctrl == 5'b11000): begin
        sgn_op = 1'b1;
        rem_op = 1'b1;
      end
      (alu_ctrl == 5'b11001): rem_op = 1'b1;
      default: valid_op = 1'b0;
    endcase
  end

  logic         accept;
  logic         a_neg;
  logic         b_neg;
  logic [W-1:0] a_abs;
  logic [W-1:0] b_abs;
  logic         div_zero;
  logic         ovf;
  logic [W-1:0] spec_res;

  assign accept   = start && valid_op && (state == IDLE || state == DONE);
  assign a_neg    = sgn_op && src1_value[W-1];
  assign b_neg    = sgn_op && src2_value[W-1];
  assign a_abs    = a_neg ? -src1_value : src1_value;
  assign b_abs    = b_neg ? -src2_value : src2_value;
  assign div_zero = (src2_value == '0);
  assign ovf      = sgn_op && (src1_value == MIN) && (src2_value == '1);

  always_comb begin
    if (div_zero)
      spec_res = rem_op ? src1_value : '1;
    else
      spec_res = rem_op ? '0 : MIN;
  end

  // Full W+1 partial remainder so divisors above 2^(W-1) still work.
  logic [W:0]   shifted;
  logic [W:0]   diff;
  logic [W-1:0] q_fix;
  logic [W-1:0] r_fix;

  assign shifted = {rem_reg, quo_reg[W-1]};
  assign diff    = shifted - {1'b0, divisor};
  assign q_fix   = (sign_a ^ sign_b) ? -quo_reg : quo_reg;
  assign r_fix   = sign_a ? -rem_reg : rem_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
      rem_reg <= '0;
      quo_reg <= '0;
      divisor <= '0;
      cnt     <= '0;
      sign_a  <= 1'b0;
      sign_b  <= 1'b0;
      is_rem  <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          done  <= 1'b0;
          state <= IDLE;
          if (accept) begin
            if (div_zero || ovf) begin
              result <= spec_res;
              done   <= 1'b1;
              state  <= DONE;
            end else begin
              rem_reg <= '0;
              quo_reg <= a_abs;
              divisor <= b_abs;
              sign_a  <= a_neg;
              sign_b  <= b_neg;
              is_rem  <= rem_op;
              cnt     <= CNT_W'(W);
              busy    <= 1'b1;
              state   <= DIV;
            end
          end
        end
        DIV: begin
          rem_reg <= diff[W] ? shifted[W-1:0] : diff[W-1:0];
          quo_reg <= {quo_reg[W-2:0], ~diff[W]};
          cnt     <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1))
            state <= FIX;
        end
        FIX: begin
          result <= is_rem ? r_fix : q_fix;
          busy   <= 1'b0;
          done   <= 1'b1;
          state  <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_rem_seq_ctrl.sv
// Scoreboard bench for div_rem_seq_ctrl: expected results queued at
// issue, popped and compared whenever done pulses.
module tb_div_rem_seq_ctrl;

  localparam logic [4:0] OP_DIV  = 5'b10110;
  localparam logic [4:0] OP_DIVU = 5'b10111;
  localparam logic [4:0] OP_REM  = 5'b11000;
  localparam logic [4:0] OP_REMU = 5'b11001;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [4:0]  alu_ctrl;
  logic [31:0] src1_value;
  logic [31:0] src2_value;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int total = 0;
  int bad   = 0;
  logic [31:0] sb[$];
  logic [31:0] last_exp;

  always #5 clk = ~clk;

  div_rem_seq_ctrl #(.DATA_WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .alu_ctrl   (alu_ctrl),
    .src1_value (src1_value),
    .src2_value (src2_value),
    .busy       (busy),
    .done       (done),
    .result     (result)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [4:0] op,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    logic s;
    logic r;
    s = (op == OP_DIV) || (op == OP_REM);
    r = (op == OP_REM) || (op == OP_REMU);
    if (b == 0) return r ? a : 32'hFFFF_FFFF;
    if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return r ? 32'h0 : 32'h8000_0000;
    if (s) return r ? $signed(a) % $signed(b) : $signed(a) / $signed(b);
    return r ? a % b : a / b;
  endfunction

  function automatic int lat_of(input logic [4:0] op,
                                input logic [31:0] a,
                                input logic [31:0] b);
    logic s;
    s = (op == OP_DIV) || (op == OP_REM);
    if (b == 0) return 1;
    if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 34;
  endfunction

  always @(negedge clk) begin
    if (!reset && done) begin
      if (sb.size() == 0)
        check("spurious_done", 32'd1, 32'd0);
      else
        check("result", result, sb.pop_front());
    end
  end

  // Called at #1 after an edge; start is sampled on the next edge.
  task automatic issue(input logic [4:0] op, input logic [31:0] a,
                       input logic [31:0] b, input bit push,
                       input logic [31:0] exp);
    start      = 1'b1;
    alu_ctrl   = op;
    src1_value = a;
    src2_value = b;
    if (push) begin
      sb.push_back(exp);
      last_exp = exp;
    end
    @(posedge clk);
    #1;
    start      = 1'b0;
    alu_ctrl   = 5'b00000;
    src1_value = $urandom;
    src2_value = $urandom;
  endtask

  // n counts edges from the accept edge inclusive.
  task automatic wait_done(input string tag, input int lat, input int n0);
    int n;
    int bc;
    n  = n0;
    bc = busy ? 1 : 0;
    while (!done && n < 200) begin
      @(posedge clk);
      #1;
      n++;
      if (busy) bc++;
    end
    check({tag, "_lat"}, n, lat);
    check({tag, "_busy"}, bc, (lat == 1) ? 0 : 34 - n0);
  endtask

  task automatic run(input string tag, input logic [4:0] op,
                     input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp);
    issue(op, a, b, 1'b1, exp);
    wait_done(tag, lat_of(op, a, b), 1);
  endtask

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    alu_ctrl   = 5'b0;
    src1_value = '0;
    src2_value = '0;
    last_exp   = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);

    run("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd14);
    run("remu_100_7", OP_REMU, 32'd100, 32'd7, 32'd2);

    // abort mid-DIV: no done may follow
    issue(OP_DIVU, 32'd1000, 32'd3, 1'b0, '0);
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_result", result, 0);
    repeat (40) @(posedge clk);
    #1;

    run("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    run("rem_m7_2", OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    run("rem_7_m2", OP_REM, 32'd7, 32'hFFFF_FFFE, 32'd1);

    run("div_5_0", OP_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF);
    run("rem_5_0", OP_REM, 32'd5, 32'd0, 32'd5);
    run("divu_max_0", OP_DIVU, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF);

    run("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);

    run("divu_big", OP_DIVU, 32'hFFFF_FFFF, 32'h8000_0001, 32'd1);
    run("remu_big", OP_REMU, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE);

    // start during DIV is ignored
    issue(OP_DIVU, 32'd100, 32'd7, 1'b1, 32'd14);
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    issue(OP_DIVU, 32'd50, 32'd5, 1'b0, '0);
    wait_done("ign_div", 34, 7);

    // back-to-back: accept on the DONE cycle
    run("b2b_first", OP_REMU, 32'd17, 32'd5, 32'd2);
    run("b2b_divu_9_3", OP_DIVU, 32'd9, 32'd3, 32'd3);

    // invalid opcode: nothing happens
    @(posedge clk);
    #1;
    issue(5'b00000, 32'd9, 32'd3, 1'b0, '0);
    for (int i = 0; i < 5; i++) begin
      check("bad_op_busy", busy, 0);
      check("bad_op_done", done, 0);
      @(posedge clk);
      #1;
    end
    check("bad_op_result", result, last_exp);

    for (int i = 0; i < 8; i++) begin
      logic [4:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      op = OP_DIV + 5'($urandom_range(0, 3));
      a  = $urandom;
      b  = (i % 3 == 0) ? 32'($urandom_range(1, 40)) : $urandom;
      if (i % 4 == 1) b = -b;
      run("rand", op, a, b, model(op, a, b));
    end

    repeat (3) @(posedge clk);
    #1;
    check("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
